counter_read_arbiter: RTL and testbench

- Shares the single read port of the 64-bit atomic event counter between NUM_REQ requesters.
- Each granted request runs a two-beat atomic read on the counter port:
  - Beat 1: atomic read returns count[31:0]; the counter snapshots count[63:32] in the same cycle.
  - Beat 2: non-atomic read returns the snapshotted high word.
- The arbiter then returns one coherent 64-bit value to the winning requester.
- It sits between software-facing requesters (CSR block, trace unit, debug) and the counter.

---
 rtl/counter_read_arbiter_if.sv | 26 ++
 rtl/counter_read_arbiter.sv | 151 +++++++++++++++
 tb/tb_counter_read_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_read_arbiter_if.sv
// rtl/counter_read_arbiter_if.sv - requester and counter-port signals of the counter read arbiter
interface counter_read_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req_i;
  logic [NUM_REQ-1:0] ack_o;
  logic [63:0]        rdata_o;
  logic               err_o;
  logic               busy_o;
  logic               cnt_req_o;
  logic               cnt_atomic_o;
  logic               cnt_ack_i;
  logic [31:0]        cnt_count_i;

  // Arbiter view: serves requesters and drives the counter read port.
  modport slave (
    input  req_i, cnt_ack_i, cnt_count_i,
    output ack_o, rdata_o, err_o, busy_o, cnt_req_o, cnt_atomic_o
  );

  // Environment view: requesters plus the counter itself.
  modport master (
    output req_i, cnt_ack_i, cnt_count_i,
    input  ack_o, rdata_o, err_o, busy_o, cnt_req_o, cnt_atomic_o
  );
endinterface

// File: rtl/counter_read_arbiter.sv
// rtl/counter_read_arbiter.sv - round-robin arbiter for two-beat coherent 64-bit counter reads
module counter_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  counter_read_arbiter_if.slave  bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] TO = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_LO,
    WAIT_LO,
    ISSUE_HI,
    WAIT_HI,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [7:0]    wait_q, wait_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   hi_q, hi_d;
  logic          err_q, err_d;

  logic [IW-1:0] win;
  logic [IW:0]   cand;
  logic          win_found;
  logic [7:0]    wait_inc;
  logic          timeout;

  // Round-robin pick: first requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (IW + 1)'(i);
      if (cand >= (IW + 1)'(NUM_REQ)) begin
        cand = cand - (IW + 1)'(NUM_REQ);
      end
      if (!win_found && bus.req_i[cand[IW-1:0]]) begin
        win       = cand[IW-1:0];
        win_found = 1'b1;
      end
    end
  end

  // Wait-state budget: the count after this cycle's miss reaching TIMEOUT aborts the beat.
  always_comb begin
    wait_inc = wait_q + 8'd1;
    timeout  = (wait_inc == TO);
  end

  // Next-state logic; an ack arriving together with the timeout still wins.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    wait_d  = wait_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = win;
          ptr_d   = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
          err_d   = 1'b0;
          state_d = ISSUE_LO;
        end
      end
      ISSUE_LO: begin
        wait_d  = '0;
        state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (bus.cnt_ack_i) begin
          lo_d    = bus.cnt_count_i;
          state_d = ISSUE_HI;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wait_d  = wait_inc;
        end
      end
      ISSUE_HI: begin
        wait_d  = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (bus.cnt_ack_i) begin
          hi_d    = bus.cnt_count_i;
          state_d = RESP;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wait_d  = wait_inc;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and data registers; reset abandons any read in flight without an ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      wait_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      wait_q  <= wait_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
    end
  end

  // Outputs decoded purely from registered state, so no input reaches an output combinationally.
  always_comb begin
    bus.cnt_req_o    = (state_q == ISSUE_LO) || (state_q == ISSUE_HI);
    bus.cnt_atomic_o = (state_q == ISSUE_LO);
    bus.busy_o       = (state_q != IDLE);
    bus.err_o        = (state_q == RESP) && err_q;
    bus.rdata_o      = ((state_q == RESP) && !err_q) ? {hi_q, lo_q} : 64'd0;
    bus.ack_o        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.ack_o[i] = (state_q == RESP) && (grant_q == IW'(i));
    end
  end

endmodule

// File: tb/tb_counter_read_arbiter.sv
// tb/tb_counter_read_arbiter.sv - scoreboard testbench for counter_read_arbiter
module tb_counter_read_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  counter_read_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  counter_read_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural 64-bit counter with a one-cycle ack and a high-word snapshot on atomic reads.
  logic [63:0] count = 64'd0;
  logic [63:0] preload = 64'd0;
  logic [31:0] snap;
  logic [31:0] cdata;
  logic        cack;
  bit          load = 1'b0;
  bit          model_en = 1'b1;
  bit          spur = 1'b0;
  bit          arm_inc = 1'b0;
  bit          inc_en = 1'b0;

  assign bus.cnt_ack_i   = cack;
  assign bus.cnt_count_i = cdata;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cack  <= 1'b0;
      cdata <= 32'd0;
      snap  <= 32'd0;
    end else begin
      cack  <= 1'b0;
      cdata <= 32'd0;
      if (spur) begin
        cack  <= 1'b1;
        cdata <= 32'hDEAD_BEEF;
      end else if (model_en && bus.cnt_req_o) begin
        cack <= 1'b1;
        if (bus.cnt_atomic_o) begin
          cdata <= count[31:0];
          snap  <= count[63:32];
        end else begin
          cdata <= snap;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (load) begin
      count  <= preload;
      inc_en <= 1'b0;
    end else if (inc_en || (arm_inc && bus.cnt_req_o && bus.cnt_atomic_o)) begin
      count  <= count + 64'd1;
      inc_en <= 1'b1;
    end
  end

  typedef struct {
    logic [NUM_REQ-1:0] ack;
    logic [63:0]        data;
    logic               err;
    int                 lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] log_req;
  logic [31:0] log_atom;
  bit          found;
  int          cyc;

  task automatic load_count(input logic [63:0] v);
    preload = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Steps cycle by cycle until an ack pulse or the budget expires; records counter-port activity.
  task automatic wait_ack(input int max_cyc, input int drop_at);
    found = 1'b0;
    cyc = 0;
    log_req = '0;
    log_atom = '0;
    while (!found && cyc < max_cyc) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (cyc < 32) begin
        log_req[cyc]  = bus.cnt_req_o;
        log_atom[cyc] = bus.cnt_atomic_o;
      end
      if (cyc == drop_at) bus.req_i = '0;
      if (bus.ack_o != '0) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_i = '0;
    @(negedge clk);
    @(negedge clk);
    n_assert++;
    if (bus.ack_o !== '0 || bus.err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ack_err: ack_o=%b err_o=%b expected 0", bus.ack_o, bus.err_o);
    end
    n_assert++;
    if (bus.busy_o !== 1'b0 || bus.cnt_req_o !== 1'b0 || bus.cnt_atomic_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy=%b cnt_req=%b atomic=%b expected 0", bus.busy_o, bus.cnt_req_o, bus.cnt_atomic_o);
    end
    n_assert++;
    if (bus.rdata_o !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h expected 0", bus.rdata_o);
    end
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [63:0] v;
    v = 64'h1234_5678_9ABC_DEF0;
    load_count(v);
    for (int k = 0; k < 5; k++) begin
      sb.push_back('{ack: NUM_REQ'(1) << (k % NUM_REQ), data: v, err: 1'b0, lat: (k == 0) ? 5 : 6});
    end
    bus.req_i = '1;
    for (int k = 0; k < 5; k++) begin
      wait_ack(40, -1);
      if (k == 4) bus.req_i = '0;
      e = sb.pop_front();
      n_assert++;
      if (!found || bus.ack_o !== e.ack) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: ack_o=%b expected %b", k, bus.ack_o, e.ack);
      end
      n_assert++;
      if (cyc != e.lat) begin
        n_fail++;
        $display("FAIL rr_spacing[%0d]: %0d cycles expected %0d", k, cyc, e.lat);
      end
      n_assert++;
      if (bus.rdata_o !== e.data) begin
        n_fail++;
        $display("FAIL rr_data[%0d]: got %h expected %h", k, bus.rdata_o, e.data);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic [63:0] v;
    v = 64'h0000_00AA_0000_0055;
    load_count(v);
    model_en = 1'b0;
    sb.push_back('{ack: 4'b0100, data: 64'd0, err: 1'b1, lat: TIMEOUT + 2});
    bus.req_i = 4'b0100;
    wait_ack(40, -1);
    bus.req_i = '0;
    e = sb.pop_front();
    n_assert++;
    if (!found || bus.ack_o !== e.ack || bus.err_o !== e.err) begin
      n_fail++;
      $display("FAIL timeout_ack: ack_o=%b err_o=%b expected %b/%b", bus.ack_o, bus.err_o, e.ack, e.err);
    end
    n_assert++;
    if (bus.rdata_o !== e.data) begin
      n_fail++;
      $display("FAIL timeout_rdata: got %h expected %h", bus.rdata_o, e.data);
    end
    n_assert++;
    if (cyc != e.lat) begin
      n_fail++;
      $display("FAIL timeout_latency: %0d cycles expected %0d", cyc, e.lat);
    end
    model_en = 1'b1;
    @(negedge clk);
    sb.push_back('{ack: 4'b1000, data: v, err: 1'b0, lat: 5});
    bus.req_i = '1;
    wait_ack(40, -1);
    bus.req_i = '0;
    e = sb.pop_front();
    n_assert++;
    if (!found || bus.ack_o !== e.ack || cyc != e.lat) begin
      n_fail++;
      $display("FAIL timeout_ptr: ack_o=%b after %0d cycles expected %b after %0d", bus.ack_o, cyc, e.ack, e.lat);
    end
    n_assert++;
    if (bus.rdata_o !== e.data || bus.err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_recover: rdata=%h err=%b expected %h/0", bus.rdata_o, bus.err_o, e.data);
    end
    @(negedge clk);
  endtask

  task automatic test_single_read();
    logic [63:0] v;
    v = 64'h0000_0001_FFFF_FFFE;
    load_count(v);
    sb.push_back('{ack: 4'b0001, data: v, err: 1'b0, lat: 5});
    bus.req_i = 4'b0001;
    wait_ack(30, 2);
    e = sb.pop_front();
    n_assert++;
    if (!found || bus.ack_o !== e.ack || cyc != e.lat) begin
      n_fail++;
      $display("FAIL single_ack: ack_o=%b after %0d cycles expected %b after %0d", bus.ack_o, cyc, e.ack, e.lat);
    end
    n_assert++;
    if (bus.rdata_o !== e.data || bus.err_o !== e.err) begin
      n_fail++;
      $display("FAIL single_data: rdata=%h err=%b expected %h/%b", bus.rdata_o, bus.err_o, e.data, e.err);
    end
    n_assert++;
    if (log_req[4:1] !== 4'b0101 || log_atom[4:1] !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_port_seq: cnt_req=%b atomic=%b expected 0101/0001", log_req[4:1], log_atom[4:1]);
    end
    @(negedge clk);
    n_assert++;
    if (bus.ack_o !== '0 || bus.busy_o !== 1'b0 || bus.rdata_o !== 64'd0) begin
      n_fail++;
      $display("FAIL single_pulse: ack_o=%b busy=%b rdata=%h expected 0", bus.ack_o, bus.busy_o, bus.rdata_o);
    end
  endtask

  task automatic test_carry();
    load_count(64'h0000_0000_FFFF_FFFF);
    arm_inc = 1'b1;
    sb.push_back('{ack: 4'b0010, data: 64'h0000_0000_FFFF_FFFF, err: 1'b0, lat: 5});
    bus.req_i = 4'b0010;
    wait_ack(30, -1);
    bus.req_i = '0;
    arm_inc = 1'b0;
    e = sb.pop_front();
    n_assert++;
    if (!found || bus.ack_o !== e.ack) begin
      n_fail++;
      $display("FAIL carry_ack: ack_o=%b expected %b", bus.ack_o, e.ack);
    end
    n_assert++;
    if (bus.rdata_o !== e.data) begin
      n_fail++;
      $display("FAIL carry_coherent: got %h expected %h", bus.rdata_o, e.data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [63:0] v;
    v = 64'h0000_0777_0000_0333;
    load_count(v);
    bus.req_i = 4'b0010;
    wait_ack(4, -1);
    n_assert++;
    if (found || bus.cnt_req_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_setup: ack seen=%0d busy=%b cnt_req=%b expected 0/1/0", found, bus.busy_o, bus.cnt_req_o);
    end
    reset = 1'b1;
    #1;
    n_assert++;
    if (bus.ack_o !== '0 || bus.busy_o !== 1'b0 || bus.cnt_req_o !== 1'b0 || bus.err_o !== 1'b0 || bus.rdata_o !== 64'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: ack=%b busy=%b cnt_req=%b err=%b rdata=%h expected 0", bus.ack_o, bus.busy_o, bus.cnt_req_o, bus.err_o, bus.rdata_o);
    end
    @(negedge clk);
    n_assert++;
    if (bus.ack_o !== '0) begin
      n_fail++;
      $display("FAIL midreset_noack: ack_o=%b expected 0", bus.ack_o);
    end
    reset = 1'b0;
    sb.push_back('{ack: 4'b0010, data: v, err: 1'b0, lat: 5});
    wait_ack(30, -1);
    bus.req_i = '0;
    e = sb.pop_front();
    n_assert++;
    if (!found || bus.ack_o !== e.ack || cyc != e.lat || bus.rdata_o !== e.data) begin
      n_fail++;
      $display("FAIL midreset_resume: ack=%b cyc=%0d rdata=%h expected %b/%0d/%h", bus.ack_o, cyc, bus.rdata_o, e.ack, e.lat, e.data);
    end
    @(negedge clk);
  endtask

  task automatic test_spurious();
    logic [63:0] v;
    v = 64'h0BAD_F00D_CAFE_0001;
    spur = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_assert++;
      if (bus.busy_o !== 1'b0 || bus.ack_o !== '0) begin
        n_fail++;
        $display("FAIL spurious_idle[%0d]: busy=%b ack=%b expected 0", k, bus.busy_o, bus.ack_o);
      end
    end
    spur = 1'b0;
    load_count(v);
    sb.push_back('{ack: 4'b1000, data: v, err: 1'b0, lat: 5});
    bus.req_i = 4'b1000;
    wait_ack(30, -1);
    bus.req_i = '0;
    e = sb.pop_front();
    n_assert++;
    if (!found || bus.ack_o !== e.ack || bus.rdata_o !== e.data || bus.err_o !== e.err) begin
      n_fail++;
      $display("FAIL spurious_read: ack=%b rdata=%h err=%b expected %b/%h/%b", bus.ack_o, bus.rdata_o, bus.err_o, e.ack, e.data, e.err);
    end
    @(negedge clk);
  endtask

  initial begin
    bus.req_i = '0;
    test_reset();
    test_round_robin();
    test_timeout();
    test_single_read();
    test_carry();
    test_reset_mid();
    test_spurious();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
